// File: rtl/univ_shift_reg_pkg.sv
// rtl/univ_shift_reg_pkg.sv - shared constants for the universal shift register
// Purpose: operation codes for the 3-bit MODE select.
// Contents: MODE_W (select width), MODE_HOLD .. MODE_ROR (operation codes).
package univ_shift_reg_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'd0;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'd1;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'd2;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'd3;
  localparam logic [MODE_W-1:0] MODE_INC  = 3'd4;
  localparam logic [MODE_W-1:0] MODE_DEC  = 3'd5;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'd6;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'd7;

endpackage

// File: rtl/univ_shift_reg_next.sv
// rtl/univ_shift_reg_next.sv - combinational next-state and carry logic
// Purpose: computes the word the register takes when enabled, plus the carry/borrow
//   flag of an INC from all ones or a DEC from zero.
// Ports:
//   mode_i     operation select
//   q_i        current register contents
//   d_i        parallel load data
//   sil_i      serial in for shift-left (enters bit 0)
//   sir_i      serial in for shift-right (enters bit WIDTH-1)
//   q_next_o   next register contents
//   co_next_o  carry/borrow for this operation
// Configuration: UNIV_SHIFT_REG_SATURATE_EN makes INC/DEC saturate instead of wrap.
module univ_shift_reg_next
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [MODE_W-1:0] mode_i,
  input  logic [WIDTH-1:0]  q_i,
  input  logic [WIDTH-1:0]  d_i,
  input  logic              sil_i,
  input  logic              sir_i,
  output logic [WIDTH-1:0]  q_next_o,
  output logic              co_next_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_comb begin
    q_next_o  = q_i;
    co_next_o = 1'b0;
    case (mode_i)
      MODE_HOLD: q_next_o = q_i;
      MODE_LOAD: q_next_o = d_i;
      MODE_SHL:  q_next_o = {q_i[WIDTH-2:0], sil_i};
      MODE_SHR:  q_next_o = {sir_i, q_i[WIDTH-1:1]};
      MODE_INC: begin
        // The carry still flags the attempt when saturating.
        co_next_o = &q_i;
`ifdef UNIV_SHIFT_REG_SATURATE_EN
        q_next_o  = (&q_i) ? q_i : q_i + ONE;
`else
        q_next_o  = q_i + ONE;
`endif
      end
      MODE_DEC: begin
        co_next_o = ~|q_i;
`ifdef UNIV_SHIFT_REG_SATURATE_EN
        q_next_o  = (~|q_i) ? q_i : q_i - ONE;
`else
        q_next_o  = q_i - ONE;
`endif
      end
      MODE_ROL:  q_next_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
      MODE_ROR:  q_next_o = {q_i[0], q_i[WIDTH-1:1]};
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal hold/load/shift/rotate/count register
// Purpose: WIDTH-bit register with priority RESET > SET > enabled MODE > hold,
//   registered carry/borrow pulse and combinational status outputs.
// Ports:
//   CLK    clock (posedge)
//   RESET  synchronous active-high reset, Q <= RST_VAL
//   EN     clock enable for MODE operations
//   SET    synchronous set, Q <= all ones
//   MODE   operation select (see univ_shift_reg_pkg)
//   D      parallel load data
//   SIL    serial in for shift-left
//   SIR    serial in for shift-right
//   Q      register contents
//   QB     ~Q
//   SOL    Q[WIDTH-1]
//   SOR    Q[0]
//   ZERO   Q == 0
//   CO     registered carry/borrow pulse
// Configuration: UNIV_SHIFT_REG_SATURATE_EN selects saturating INC/DEC.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              EN,
  input  logic              SET,
  input  logic [MODE_W-1:0] MODE,
  input  logic [WIDTH-1:0]  D,
  input  logic              SIL,
  input  logic              SIR,
  output logic [WIDTH-1:0]  Q,
  output logic [WIDTH-1:0]  QB,
  output logic              SOL,
  output logic              SOR,
  output logic              ZERO,
  output logic              CO
);

  logic [WIDTH-1:0] q_q, q_d, q_next;
  logic             co_q, co_d, co_next;

  univ_shift_reg_next #(.WIDTH(WIDTH)) u_next (
    .mode_i    (MODE),
    .q_i       (q_q),
    .d_i       (D),
    .sil_i     (SIL),
    .sir_i     (SIR),
    .q_next_o  (q_next),
    .co_next_o (co_next)
  );

  // CO is a one-cycle pulse: any edge without a qualifying INC/DEC clears it.
  always_comb begin
    q_d  = q_q;
    co_d = 1'b0;
    if (SET) begin
      q_d = '1;
    end else if (EN) begin
      q_d  = q_next;
      co_d = co_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      q_q  <= RST_VAL;
      co_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      co_q <= co_d;
    end
  end

  assign Q    = q_q;
  assign QB   = ~q_q;
  assign SOL  = q_q[WIDTH-1];
  assign SOR  = q_q[0];
  assign ZERO = ~|q_q;
  assign CO   = co_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - self-checking bench for univ_shift_reg (WIDTH=8)
// Two instances (RST_VAL 8'h00 and 8'hA5) share stimulus; an arithmetic model
// predicts both. Honours UNIV_SHIFT_REG_SATURATE_EN.
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b0, set = 1'b0, en = 1'b0, sil = 1'b0, sir = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] d = 8'h00;

  logic [7:0] q0, qb0, q1, qb1;
  logic       sol0, sor0, zero0, co0, sol1, sor1, zero1, co1;

  int checks = 0;
  int failures = 0;

  int  m0 = 0, m1 = 0;
  bit  mco0 = 1'b0, mco1 = 1'b0;
  bit  valid = 1'b0;

`ifdef UNIV_SHIFT_REG_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h00)) dut0 (
    .CLK(clk), .RESET(rst), .EN(en), .SET(set), .MODE(mode), .D(d),
    .SIL(sil), .SIR(sir), .Q(q0), .QB(qb0), .SOL(sol0), .SOR(sor0),
    .ZERO(zero0), .CO(co0)
  );

  univ_shift_reg #(.WIDTH(8), .RST_VAL(8'hA5)) dut1 (
    .CLK(clk), .RESET(rst), .EN(en), .SET(set), .MODE(mode), .D(d),
    .SIL(sil), .SIR(sir), .Q(q1), .QB(qb1), .SOL(sol1), .SOR(sor1),
    .ZERO(zero1), .CO(co1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the register as an integer 0..255.
  function automatic int model_q(int q, int rv);
    if (rst) return rv;
    if (set) return 255;
    if (!en) return q;
    case (int'(mode))
      1: return int'(d);
      2: return (q * 2 + int'(sil)) % 256;
      3: return q / 2 + 128 * int'(sir);
      4: return (SAT && q == 255) ? 255 : (q + 1) % 256;
      5: return (SAT && q == 0) ? 0 : (q + 255) % 256;
      6: return (q * 2) % 256 + q / 128;
      7: return q / 2 + 128 * (q % 2);
      default: return q;
    endcase
  endfunction

  function automatic bit model_co(int q);
    if (rst || set || !en) return 1'b0;
    if (mode == 3'd4) return q == 255;
    if (mode == 3'd5) return q == 0;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    mco0 = model_co(m0);
    mco1 = model_co(m1);
    m0   = model_q(m0, 8'h00);
    m1   = model_q(m1, 8'hA5);
    if (rst) valid = 1'b1;
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (valid) begin
      check("dut0.Q",    32'(q0),    32'(m0));
      check("dut0.QB",   32'(qb0),   32'(255 - m0));
      check("dut0.SOL",  32'(sol0),  32'(m0 / 128));
      check("dut0.SOR",  32'(sor0),  32'(m0 % 2));
      check("dut0.ZERO", 32'(zero0), 32'(m0 == 0));
      check("dut0.CO",   32'(co0),   32'(mco0));
      check("dut1.Q",    32'(q1),    32'(m1));
      check("dut1.QB",   32'(qb1),   32'(255 - m1));
      check("dut1.SOL",  32'(sol1),  32'(m1 / 128));
      check("dut1.SOR",  32'(sor1),  32'(m1 % 2));
      check("dut1.ZERO", 32'(zero1), 32'(m1 == 0));
      check("dut1.CO",   32'(co1),   32'(mco1));
    end
  end

  task automatic step(input bit r, input bit s, input bit e, input logic [2:0] md,
                      input logic [7:0] dd, input bit sl, input bit sr);
    rst = r; set = s; en = e; mode = md; d = dd; sil = sl; sir = sr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1. reset
    step(1, 0, 0, 3'd0, 8'h00, 0, 0);
    check("rst_q",    32'(q0), 32'h00);
    check("rst_zero", 32'(zero0), 32'h1);
    check("rst_co",   32'(co0), 32'h0);
    check("rst_qb",   32'(qb0), 32'hFF);
    check("rst_a5",   32'(q1), 32'hA5);
    // 2. load / shifts
    step(0, 0, 1, 3'd1, 8'h81, 0, 0);
    step(0, 0, 1, 3'd2, 8'h00, 0, 0);
    check("shl_q",   32'(q0), 32'h02);
    check("shl_sol", 32'(sol0), 32'h0);
    step(0, 0, 1, 3'd3, 8'h00, 0, 1);
    check("shr_q",   32'(q0), 32'h81);
    check("shr_sor", 32'(sor0), 32'h1);
    // 3. increment across the top
    step(0, 0, 1, 3'd1, 8'hFE, 0, 0);
    step(0, 0, 1, 3'd4, 8'h00, 0, 0);
    check("inc1_q",  32'(q0), 32'hFF);
    check("inc1_co", 32'(co0), 32'h0);
    step(0, 0, 1, 3'd4, 8'h00, 0, 0);
    check("inc2_q",  32'(q0), SAT ? 32'hFF : 32'h00);
    check("inc2_co", 32'(co0), 32'h1);
    check("inc2_zero", 32'(zero0), SAT ? 32'h0 : 32'h1);
    step(0, 0, 1, 3'd0, 8'h00, 0, 0);
    check("inc_co_pulse", 32'(co0), 32'h0);
    // 4. decrement below zero
    step(0, 0, 1, 3'd1, 8'h00, 0, 0);
    step(0, 0, 1, 3'd5, 8'h00, 0, 0);
    check("dec_q",  32'(q0), SAT ? 32'h00 : 32'hFF);
    check("dec_co", 32'(co0), 32'h1);
    step(0, 0, 1, 3'd0, 8'h00, 0, 0);
    check("dec_hold_co", 32'(co0), 32'h0);
    // 5. rotates and enable
    step(0, 0, 1, 3'd1, 8'h96, 0, 0);
    step(0, 0, 1, 3'd6, 8'h00, 0, 0);
    check("rol_q", 32'(q0), 32'h2D);
    step(0, 0, 1, 3'd7, 8'h00, 0, 0);
    check("ror_q", 32'(q0), 32'h96);
    step(0, 0, 0, 3'd6, 8'h00, 0, 0);
    check("en0_q", 32'(q0), 32'h96);
    // 6. same-edge conflicts
    step(0, 1, 1, 3'd1, 8'h12, 0, 0);
    check("set_load_q", 32'(q0), 32'hFF);
    step(1, 1, 1, 3'd1, 8'h12, 0, 0);
    check("set_rst_q0", 32'(q0), 32'h00);
    check("set_rst_q1", 32'(q1), 32'hA5);
    step(0, 0, 1, 3'd1, 8'hFF, 0, 0);
    step(1, 0, 1, 3'd4, 8'h00, 0, 0);
    check("rst_inc_q",  32'(q0), 32'h00);
    check("rst_inc_co", 32'(co0), 32'h0);
    // Randomized traffic checked by the per-cycle compare.
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
           8'($urandom), 1'($urandom), 1'($urandom));
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
